// File: rtl/alu_writeback_stage_pkg.sv
// Shared types for the ALU writeback stage.
//   CPU_*_WIDTH   : default CPU datapath widths
//   ALU_WB_DEPTH  : writeback buffer depth
//   flag_idx_e    : bit position of each flag inside the flags vector
//   StrcAluWbEntry: one buffered register-file write {rd, data}
package alu_writeback_stage_pkg;

   localparam int unsigned CPU_WORD_WIDTH     = 32;
   localparam int unsigned CPU_REG_ADDR_WIDTH = 4;
   localparam int unsigned CPU_FLAGS_WIDTH    = 4;
   localparam int unsigned ALU_WB_DEPTH       = 2;

   typedef enum logic [1:0] {
      FlagC = 2'd0,
      FlagZ = 2'd1,
      FlagV = 2'd2,
      FlagN = 2'd3
   } flag_idx_e;

   typedef struct packed {
      logic [CPU_REG_ADDR_WIDTH-1:0] rd;
      logic [CPU_WORD_WIDTH-1:0]     data;
   } StrcAluWbEntry;

endpackage

// File: rtl/alu_writeback_stage_if.sv
// Bus bundle between the ALU, the writeback stage and the register file.
//   in_*    : ALU result handshake (in_valid/in_ready) with data, flags, rd, write enables
//   flags_q : architectural flags back to the ALU
//   rf_*    : register-file write port handshake (rf_we/rf_ready) with addr/data
//   query_* : operand hazard check / forwarding
// Modport slave is the writeback stage; master is everything around it.
interface alu_writeback_stage_if #(
   parameter int unsigned WORD_WIDTH     = 32,
   parameter int unsigned REG_ADDR_WIDTH = 4,
   parameter int unsigned FLAGS_WIDTH    = 4
);
   logic                      in_valid;
   logic                      in_ready;
   logic [WORD_WIDTH-1:0]     in_data;
   logic [FLAGS_WIDTH-1:0]    in_flags;
   logic [REG_ADDR_WIDTH-1:0] in_rd;
   logic                      in_wr_rd;
   logic                      in_wr_flags;
   logic [FLAGS_WIDTH-1:0]    flags_q;
   logic                      rf_we;
   logic                      rf_ready;
   logic [REG_ADDR_WIDTH-1:0] rf_addr;
   logic [WORD_WIDTH-1:0]     rf_data;
   logic [REG_ADDR_WIDTH-1:0] query_addr;
   logic                      query_pending;
   logic                      query_hit;
   logic [WORD_WIDTH-1:0]     query_data;

   modport master (
      output in_valid, in_data, in_flags, in_rd, in_wr_rd, in_wr_flags, rf_ready, query_addr,
      input  in_ready, flags_q, rf_we, rf_addr, rf_data, query_pending, query_hit, query_data
   );

   modport slave (
      input  in_valid, in_data, in_flags, in_rd, in_wr_rd, in_wr_flags, rf_ready, query_addr,
      output in_ready, flags_q, rf_we, rf_addr, rf_data, query_pending, query_hit, query_data
   );
endinterface

// File: rtl/alu_wb_fifo2.sv
// Two-entry in-order buffer of pending register-file writes.
//   clk, rst_n  : clock, async active-low reset (clears storage, pointers, count)
//   push        : write push_entry at the tail (ignored when full)
//   pop         : drop the head entry (ignored when empty)
//   head_entry  : oldest entry; next_entry: younger entry (valid only when next_valid)
//   full, empty : occupancy flags
module alu_wb_fifo2
   import alu_writeback_stage_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic          pop,
   input  StrcAluWbEntry push_entry,
   output StrcAluWbEntry head_entry,
   output StrcAluWbEntry next_entry,
   output logic          next_valid,
   output logic          full,
   output logic          empty
);

   StrcAluWbEntry mem_q [ALU_WB_DEPTH];
   logic          head_q;
   logic [1:0]    count_q, count_d;
   logic          push_ok, pop_ok;
   logic          tail_idx;

   assign full     = (count_q == 2'd2);
   assign empty    = (count_q == 2'd0);
   assign push_ok  = push & ~full;
   assign pop_ok   = pop & ~empty;
   // Slot after the head when one entry is held, the head slot itself when empty.
   assign tail_idx = head_q ^ count_q[0];

   always_comb begin
      count_d = count_q;
      unique case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < ALU_WB_DEPTH; i++) mem_q[i] <= '0;
         head_q  <= 1'b0;
         count_q <= 2'd0;
      end else begin
         if (push_ok) mem_q[tail_idx] <= push_entry;
         if (pop_ok)  head_q <= ~head_q;
         count_q <= count_d;
      end
   end

   assign head_entry = mem_q[head_q];
   assign next_entry = mem_q[~head_q];
   assign next_valid = full;

endmodule

// File: rtl/alu_writeback_stage.sv
// ALU execute/writeback stage: buffers ALU results in order, drains them into the
// register-file write port, owns the architectural flags register and answers
// operand hazard queries.
//   clk, rst_n : clock, async active-low reset
//   bus        : alu_writeback_stage_if.slave (in_*, flags_q, rf_*, query_*)
// Optional build macro ALU_WB_FORWARD_EN: when defined, query_hit/query_data forward
// the youngest matching buffered value; otherwise both are tied to zero.
module alu_writeback_stage
   import alu_writeback_stage_pkg::*;
#(
   parameter int unsigned            WORD_WIDTH     = CPU_WORD_WIDTH,
   parameter int unsigned            REG_ADDR_WIDTH = CPU_REG_ADDR_WIDTH,
   parameter int unsigned            FLAGS_WIDTH    = CPU_FLAGS_WIDTH,
   parameter logic [FLAGS_WIDTH-1:0] FLAGS_RESET    = '0
) (
   input logic                clk,
   input logic                rst_n,
   alu_writeback_stage_if.slave bus
);

   StrcAluWbEntry          head_entry, next_entry, push_entry;
   logic                   next_valid, full, empty;
   logic                   accept;
   logic                   head_match, next_match;
   logic [FLAGS_WIDTH-1:0] arch_flags_q;

   // in_ready depends only on buffer occupancy, never on rf_ready.
   assign bus.in_ready = ~full;
   assign accept       = bus.in_valid & ~full;

   assign push_entry.rd   = bus.in_rd;
   assign push_entry.data = bus.in_data;

   alu_wb_fifo2 u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .push       (accept & bus.in_wr_rd),
      .pop        (bus.rf_ready),
      .push_entry (push_entry),
      .head_entry (head_entry),
      .next_entry (next_entry),
      .next_valid (next_valid),
      .full       (full),
      .empty      (empty)
   );

   assign bus.rf_we   = ~empty;
   assign bus.rf_addr = head_entry.rd;
   assign bus.rf_data = head_entry.data;

   // Updated on the accept edge so a dependent op issued next cycle sees the new carry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         arch_flags_q <= FLAGS_RESET;
      end else if (accept && bus.in_wr_flags) begin
         arch_flags_q <= bus.in_flags;
      end
   end

   assign bus.flags_q = arch_flags_q;

   assign head_match        = ~empty & (head_entry.rd == bus.query_addr);
   assign next_match        = next_valid & (next_entry.rd == bus.query_addr);
   assign bus.query_pending = head_match | next_match;

`ifdef ALU_WB_FORWARD_EN
   assign bus.query_hit = bus.query_pending;
   // Younger entry wins: it holds the most recent value of the register.
   assign bus.query_data = next_match ? next_entry.data :
                           head_match ? head_entry.data : '0;
`else
   logic unused_next_data;
   assign unused_next_data = ^next_entry.data;
   assign bus.query_hit    = 1'b0;
   assign bus.query_data   = '0;
`endif

endmodule

// File: tb/tb_alu_writeback_stage.sv
module tb_alu_writeback_stage;
   import alu_writeback_stage_pkg::*;

   typedef struct {
      logic [3:0]  rd;
      logic [31:0] data;
   } ent_t;

   logic clk = 1'b0;
   logic rst_n;
   int   n_checks = 0;
   int   n_fail   = 0;

`ifdef ALU_WB_FORWARD_EN
   localparam bit Fwd = 1'b1;
`else
   localparam bit Fwd = 1'b0;
`endif

   alu_writeback_stage_if bus ();

   alu_writeback_stage dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: in-order queue of pending writes plus the flags register.
   ent_t       mq[$];
   logic [3:0] m_flags;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mq.delete();
         m_flags <= 4'b0000;
      end else begin
         bit acc;
         bit pop;
         ent_t e;
         acc = bus.in_valid && (mq.size() < 2);
         pop = (mq.size() > 0) && bus.rf_ready;
         if (pop) void'(mq.pop_front());
         if (acc && bus.in_wr_rd) begin
            e.rd   = bus.in_rd;
            e.data = bus.in_data;
            mq.push_back(e);
         end
         if (acc && bus.in_wr_flags) m_flags <= bus.in_flags;
      end
   end

   always @(posedge clk) begin
      #1;
      if (rst_n) begin
         bit          pend;
         logic [31:0] fdata;
         pend  = 1'b0;
         fdata = 32'h0;
         foreach (mq[i]) begin
            if (mq[i].rd == bus.query_addr) begin
               pend  = 1'b1;
               fdata = mq[i].data;
            end
         end
         check("m_in_ready", bus.in_ready, mq.size() < 2);
         check("m_rf_we", bus.rf_we, mq.size() > 0);
         check("m_flags_q", bus.flags_q, m_flags);
         if (mq.size() > 0) begin
            check("m_rf_addr", bus.rf_addr, mq[0].rd);
            check("m_rf_data", bus.rf_data, mq[0].data);
         end
         check("m_query_pending", bus.query_pending, pend);
         check("m_query_hit", bus.query_hit, Fwd ? pend : 1'b0);
         check("m_query_data", bus.query_data, Fwd ? fdata : 32'h0);
      end
   end

   task automatic drive(input logic v, input logic [3:0] rd, input logic [31:0] d,
                        input logic wrd, input logic wfl, input logic [3:0] fl);
      bus.in_valid    = v;
      bus.in_rd       = rd;
      bus.in_data     = d;
      bus.in_wr_rd    = wrd;
      bus.in_wr_flags = wfl;
      bus.in_flags    = fl;
   endtask

   task automatic idle();
      drive(1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 4'h0);
   endtask

   initial begin
      rst_n          = 1'b0;
      idle();
      bus.rf_ready   = 1'b0;
      bus.query_addr = 4'h0;
      @(negedge clk);
      check("rst_in_ready", bus.in_ready, 1'b1);
      check("rst_rf_we", bus.rf_we, 1'b0);
      check("rst_rf_addr", bus.rf_addr, 4'h0);
      check("rst_rf_data", bus.rf_data, 32'h0);
      check("rst_flags", bus.flags_q, 4'b0000);
      check("rst_query_pending", bus.query_pending, 1'b0);
      check("rst_query_hit", bus.query_hit, 1'b0);
      check("rst_query_data", bus.query_data, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // Single op through an empty stage.
      drive(1'b1, 4'd3, 32'h5, 1'b1, 1'b1, 4'b0010);
      bus.rf_ready = 1'b1;
      @(negedge clk);
      check("t1_rf_we", bus.rf_we, 1'b1);
      check("t1_rf_addr", bus.rf_addr, 4'd3);
      check("t1_rf_data", bus.rf_data, 32'h5);
      check("t1_flags", bus.flags_q, 4'b0010);
      idle();
      @(negedge clk);
      check("t1_drained", bus.rf_we, 1'b0);

      // Fill to full with the port stalled, third op held.
      bus.rf_ready = 1'b0;
      drive(1'b1, 4'd1, 32'h11, 1'b1, 1'b0, 4'h0);
      @(negedge clk);
      drive(1'b1, 4'd2, 32'h22, 1'b1, 1'b0, 4'h0);
      @(negedge clk);
      check("t2_full_ready", bus.in_ready, 1'b0);
      check("t2_head_addr", bus.rf_addr, 4'd1);
      drive(1'b1, 4'd9, 32'h99, 1'b1, 1'b1, 4'b0100);
      @(negedge clk);
      check("t2_held_ready", bus.in_ready, 1'b0);
      check("t2_held_flags", bus.flags_q, 4'b0010);
      check("t2_head_data", bus.rf_data, 32'h11);
      bus.rf_ready = 1'b1;
      @(negedge clk);
      check("t2_second_data", bus.rf_data, 32'h22);
      check("t2_ready_back", bus.in_ready, 1'b1);
      @(negedge clk);
      check("t2_third_addr", bus.rf_addr, 4'd9);
      check("t2_third_data", bus.rf_data, 32'h99);
      check("t2_third_flags", bus.flags_q, 4'b0100);
      idle();
      @(negedge clk);
      check("t2_empty", bus.rf_we, 1'b0);

      // Push and pop on the same edge with one entry held.
      bus.rf_ready = 1'b0;
      drive(1'b1, 4'd4, 32'h44, 1'b1, 1'b0, 4'h0);
      @(negedge clk);
      check("t3_head4", bus.rf_addr, 4'd4);
      bus.rf_ready = 1'b1;
      drive(1'b1, 4'd5, 32'hAA, 1'b1, 1'b0, 4'h0);
      @(negedge clk);
      check("t3_we", bus.rf_we, 1'b1);
      check("t3_addr", bus.rf_addr, 4'd5);
      check("t3_data", bus.rf_data, 32'hAA);
      check("t3_ready", bus.in_ready, 1'b1);
      idle();
      bus.rf_ready = 1'b0;
      @(negedge clk);
      check("t3_kept", bus.rf_addr, 4'd5);
      bus.rf_ready = 1'b1;
      @(negedge clk);
      check("t3_empty", bus.rf_we, 1'b0);

      // Flag-only op, then a no-effect op.
      drive(1'b1, 4'd0, 32'h0, 1'b0, 1'b1, 4'b1001);
      @(negedge clk);
      check("t4_flags", bus.flags_q, 4'b1001);
      check("t4_no_we", bus.rf_we, 1'b0);
      drive(1'b1, 4'd0, 32'h0, 1'b0, 1'b0, 4'b0110);
      @(negedge clk);
      check("t4_noop_flags", bus.flags_q, 4'b1001);
      check("t4_noop_we", bus.rf_we, 1'b0);

      // Queries against distinct registers.
      bus.rf_ready = 1'b0;
      drive(1'b1, 4'd6, 32'h66, 1'b1, 1'b0, 4'h0);
      @(negedge clk);
      drive(1'b1, 4'd8, 32'h88, 1'b1, 1'b0, 4'h0);
      @(negedge clk);
      idle();
      bus.query_addr = 4'd6;
      #1;
      check("t5_pend6", bus.query_pending, 1'b1);
      check("t5_data6", bus.query_data, Fwd ? 32'h66 : 32'h0);
      bus.query_addr = 4'd8;
      #1;
      check("t5_data8", bus.query_data, Fwd ? 32'h88 : 32'h0);
      bus.query_addr = 4'd3;
      #1;
      check("t5_pend3", bus.query_pending, 1'b0);
      bus.rf_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("t5_empty", bus.rf_we, 1'b0);

      // Same register twice: youngest value forwards; then reset mid-cycle.
      bus.rf_ready = 1'b0;
      drive(1'b1, 4'd7, 32'h1, 1'b1, 1'b1, 4'b1111);
      @(negedge clk);
      drive(1'b1, 4'd7, 32'h2, 1'b1, 1'b0, 4'h0);
      bus.query_addr = 4'd7;
      @(negedge clk);
      idle();
      check("t6_pend7", bus.query_pending, 1'b1);
      check("t6_hit7", bus.query_hit, Fwd);
      check("t6_data7", bus.query_data, Fwd ? 32'h2 : 32'h0);
      check("t6_flags", bus.flags_q, 4'b1111);
      check("t6_full", bus.in_ready, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      check("t6_rst_we", bus.rf_we, 1'b0);
      check("t6_rst_flags", bus.flags_q, 4'b0000);
      check("t6_rst_ready", bus.in_ready, 1'b1);
      check("t6_rst_pend", bus.query_pending, 1'b0);
      check("t6_rst_hit", bus.query_hit, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      bus.rf_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("t6_no_write", bus.rf_we, 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
